// File: rtl/tap_tempo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tap_tempo_ctrl_pkg
//   Shared definitions for the effect-rate controllers.
//   - PRESCALE_W : width of the 1 ms tick prescaler. It covers a 50 MHz clock
//                  (50000 cycles per ms), and the other controllers reuse it.
//   - tap_state_e: tap-tempo measurement states.
//       IDLE  : no tap is pending.
//       FIRST : one tap has been seen and no interval has been measured yet.
//       AVG   : later taps are averaged into the period.
// ---------------------------------------------------------------------------
package tap_tempo_ctrl_pkg;

    localparam int PRESCALE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        AVG   = 2'd2
    } tap_state_e;

endpackage

// File: rtl/tap_debounce.sv
// ---------------------------------------------------------------------------
// tap_debounce
//   Conditions the raw footswitch into a single-cycle tap event. The path is:
//   a two-flop synchroniser, then a debouncer clocked by the 1 ms tick, then a
//   press-edge detector.
//   Ports:
//     clk_in  in   system clock
//     rst     in   asynchronous reset, active-high
//     ms_tick in   one-cycle pulse every millisecond
//     btn_n   in   raw pushbutton, active-low, asynchronous to clk_in
//     tap     out  one-cycle pulse on the debounced press (1->0) edge
// ---------------------------------------------------------------------------
module tap_debounce #(
    parameter int DEBOUNCE_MS = 10
) (
    input  logic clk_in,
    input  logic rst,
    input  logic ms_tick,
    input  logic btn_n,
    output logic tap
);

    localparam int             CW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_MS - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          tap_q,   tap_d;

    // The synchroniser flops and the debounced level reset to 1, the
    // released state of the button, so that reset does not produce a tap.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            tap_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            tap_q   <= tap_d;
        end
    end

    // The debounced level follows the synced input only after the two have
    // differed for DEBOUNCE_MS ticks in a row. Any return to agreement clears
    // the count, so a short glitch has to start again from zero.
    always_comb begin
        sync1_d = btn_n;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (ms_tick) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        // Only a press (falling edge) makes a tap. A release makes no event.
        tap_d = level_q & ~level_d;
    end

    assign tap = tap_q;

endmodule

// File: rtl/tap_tempo_ctrl.sv
// ---------------------------------------------------------------------------
// tap_tempo_ctrl
//   Tap-tempo controller for the modulation and delay effects. It measures
//   the time between footswitch taps and keeps a smoothed beat period in
//   milliseconds. It also emits a beat pulse at that period. period_ms drives
//   the rate setting of the effect clock dividers and LFOs.
//   Ports:
//     clk_in       in   system clock
//     rst          in   asynchronous reset, active-high
//     tap_n        in   raw pushbutton, active-low, asynchronous
//     period_ms    out  current beat period in ms (W bits)
//     period_valid out  one-cycle pulse when period_ms has just been updated
//     beat         out  one-cycle pulse once per period
//     indicator    out  LED level that toggles on every beat
// ---------------------------------------------------------------------------
module tap_tempo_ctrl
    import tap_tempo_ctrl_pkg::*;
#(
    parameter int TICK_DIV    = 50000,
    parameter int DEBOUNCE_MS = 10,
    parameter int MIN_MS      = 100,
    parameter int MAX_MS      = 2000,
    parameter int DEFAULT_MS  = 500,
    parameter int W           = 12
) (
    input  logic         clk_in,
    input  logic         rst,
    input  logic         tap_n,
    output logic [W-1:0] period_ms,
    output logic         period_valid,
    output logic         beat,
    output logic         indicator
);

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(TICK_DIV - 1);
    localparam logic [W-1:0]          MIN_V      = W'(MIN_MS);
    localparam logic [W-1:0]          MAX_V      = W'(MAX_MS);
    localparam logic [W-1:0]          DEFAULT_V  = W'(DEFAULT_MS);

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic                  ms_tick;
    logic                  tap;

    tap_state_e            state_q, state_d;
    logic [W-1:0]          interval_q, interval_d;
    logic [W-1:0]          period_q, period_d;
    logic                  period_valid_q, period_valid_d;
    logic [W-1:0]          beat_cnt_q, beat_cnt_d;
    logic                  beat_q, beat_d;
    logic                  indicator_q, indicator_d;
    logic                  accept;
    logic [W-1:0]          period_avg;

    tap_debounce #(
        .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_debounce (
        .clk_in (clk_in),
        .rst    (rst),
        .ms_tick(ms_tick),
        .btn_n  (tap_n),
        .tap    (tap)
    );

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            presc_q        <= '0;
            state_q        <= IDLE;
            interval_q     <= '0;
            period_q       <= DEFAULT_V;
            period_valid_q <= 1'b0;
            beat_cnt_q     <= '0;
            beat_q         <= 1'b0;
            indicator_q    <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            state_q        <= state_d;
            interval_q     <= interval_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            beat_cnt_q     <= beat_cnt_d;
            beat_q         <= beat_d;
            indicator_q    <= indicator_d;
        end
    end

    // Millisecond prescaler. The tick is high for the last count before wrap.
    always_comb begin
        ms_tick = (presc_q == PRESC_LAST);
        presc_d = ms_tick ? '0 : presc_q + PRESCALE_W'(1);
    end

    // Measurement FSM. The timeout is checked before the tap, so that an
    // interval that has saturated never becomes a period. An accepted tap
    // clears the interval, which also drops an ms tick that arrives on the
    // same cycle. A tap that comes too early is ignored and the interval
    // keeps counting.
    always_comb begin
        state_d        = state_q;
        interval_d     = interval_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        accept         = 1'b0;
        // The sum has W+1 bits so that the carry survives the halving.
        period_avg     = W'(({1'b0, period_q} + {1'b0, interval_q}) >> 1);
        case (state_q)
            IDLE: begin
                interval_d = '0;
                if (tap) begin
                    state_d = FIRST;
                end
            end
            FIRST, AVG: begin
                if (interval_q == MAX_V) begin
                    state_d    = IDLE;
                    interval_d = '0;
                end else if (tap && (interval_q >= MIN_V)) begin
                    accept         = 1'b1;
                    period_valid_d = 1'b1;
                    interval_d     = '0;
                    state_d        = AVG;
                    period_d       = (state_q == FIRST) ? interval_q : period_avg;
                end else if (ms_tick) begin
                    interval_d = interval_q + W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                interval_d = '0;
            end
        endcase
    end

    // The beat generator runs free in every state. An accepted tap restarts
    // the phase, so a beat lands on the same cycle as period_valid. This also
    // keeps beat_cnt below a newly shortened period.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        beat_d      = 1'b0;
        indicator_d = indicator_q;
        if (accept) begin
            beat_d      = 1'b1;
            beat_cnt_d  = '0;
            indicator_d = ~indicator_q;
        end else if (ms_tick) begin
            if (beat_cnt_q == period_q - W'(1)) begin
                beat_d      = 1'b1;
                beat_cnt_d  = '0;
                indicator_d = ~indicator_q;
            end else begin
                beat_cnt_d = beat_cnt_q + W'(1);
            end
        end
    end

    assign period_ms    = period_q;
    assign period_valid = period_valid_q;
    assign beat         = beat_q;
    assign indicator    = indicator_q;

endmodule

// File: tb/tb_tap_tempo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tap_tempo_ctrl
//   Directed bench for tap_tempo_ctrl. It uses a short prescaler, so one ms is
//   4 clocks. Every tap that should update the period pushes its expected
//   period_ms onto a queue. A monitor pops that value when period_valid
//   pulses. Presses always start on the same prescaler phase, so the number
//   of ms between press starts is the interval that the DUT measures.
// ---------------------------------------------------------------------------
module tb_tap_tempo_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int DEBOUNCE_MS = 2;
    localparam int MIN_MS      = 10;
    localparam int MAX_MS      = 200;
    localparam int DEFAULT_MS  = 50;
    localparam int W           = 12;
    localparam int HOLD_MS     = 2;

    logic         clk_in = 1'b0;
    logic         rst    = 1'b1;
    logic         tap_n  = 1'b1;
    logic [W-1:0] period_ms;
    logic         period_valid;
    logic         beat;
    logic         indicator;

    int          pass_cnt   = 0;
    int          check_cnt  = 0;
    int          fail_cnt   = 0;
    int unsigned cyc        = 0;
    int unsigned cyc0       = 0;
    int          last_press = 0;
    int          restart_at = 0;
    int          exp_q[$];

    tap_tempo_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .MIN_MS     (MIN_MS),
        .MAX_MS     (MAX_MS),
        .DEFAULT_MS (DEFAULT_MS),
        .W          (W)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .tap_n       (tap_n),
        .period_ms   (period_ms),
        .period_valid(period_valid),
        .beat        (beat),
        .indicator   (indicator)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Cycle window index since the last reset release.
    function automatic int now_idx();
        return int'(cyc - cyc0);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance to just after the posedge that opens the target window.
    task automatic waitUntil(input int target);
        while (now_idx() < target) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Press for HOLD_MS, starting gap_ms after the previous press start.
    // When the tap should update the period, push the expected value first.
    task automatic applyStimulus(input int gap_ms, input bit expect_update,
                                 input int exp_period);
        int target;
        target = last_press + gap_ms * TICK_DIV;
        waitUntil(target);
        last_press = target;
        if (expect_update) exp_q.push_back(exp_period);
        tap_n = 1'b0;
        waitUntil(target + HOLD_MS * TICK_DIV);
        tap_n = 1'b1;
        waitUntil(target + 2 * HOLD_MS * TICK_DIV);
        checkOutput("tap_update_pending", exp_q.size(), 0);
    endtask

    task automatic waitBeat(input int bound, output int at);
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (beat !== 1'b1 && n < bound);
        checkOutput("beat_within_bound", beat, 1);
        at = now_idx();
    endtask

    // Scoreboard: every period_valid must match an expected update, in order.
    always @(negedge clk_in) begin
        if (!rst && period_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_period_valid", period_valid, 0);
            end else begin
                checkOutput("period_ms", period_ms, exp_q.pop_front());
                checkOutput("beat_on_update", beat, 1);
                restart_at = now_idx();
            end
        end
    end

    initial begin
        int at;
        int prev;
        int accepted;

        // Reset, then the default period with no taps.
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst  = 1'b0;
        cyc0 = cyc;
        checkOutput("reset_period_ms", period_ms, DEFAULT_MS);
        checkOutput("reset_period_valid", period_valid, 0);
        checkOutput("reset_beat", beat, 0);
        checkOutput("reset_indicator", indicator, 0);

        waitBeat(300, at);
        checkOutput("first_beat_window", at, DEFAULT_MS * TICK_DIV);
        checkOutput("indicator_beat1", indicator, 1);
        @(negedge clk_in);
        checkOutput("beat_one_cycle", beat, 0);
        prev = at;
        waitBeat(300, at);
        checkOutput("idle_beat_gap1", at - prev, DEFAULT_MS * TICK_DIV);
        checkOutput("indicator_beat2", indicator, 0);
        prev = at;
        waitBeat(300, at);
        checkOutput("idle_beat_gap2", at - prev, DEFAULT_MS * TICK_DIV);
        checkOutput("indicator_beat3", indicator, 1);
        checkOutput("idle_period_ms", period_ms, DEFAULT_MS);

        // Clean taps: the first only arms, then 100, (100+60)>>1, (80+81)>>1.
        last_press = ((now_idx() / TICK_DIV) + 2) * TICK_DIV;
        applyStimulus(0, 1'b0, 0);
        applyStimulus(100, 1'b1, 100);
        applyStimulus(60, 1'b1, 80);
        applyStimulus(81, 1'b1, 80);

        // Double tap 5 ms later is ignored.
        accepted = last_press;
        applyStimulus(5, 1'b0, 0);
        checkOutput("period_after_double_tap", period_ms, 80);

        // A 1 ms glitch must not produce a tap.
        waitUntil(accepted + 20 * TICK_DIV);
        tap_n = 1'b0;
        waitUntil(accepted + 21 * TICK_DIV);
        tap_n = 1'b1;
        waitUntil(accepted + 30 * TICK_DIV);
        checkOutput("period_after_glitch", period_ms, 80);

        // The interval kept counting through both: 50 ms -> (80+50)>>1.
        last_press = accepted;
        applyStimulus(50, 1'b1, 65);
        waitBeat(300, at);
        checkOutput("beat_gap_after_restart",
                    ((at - restart_at) > (65 - 1) * TICK_DIV) &&
                    ((at - restart_at) <= 65 * TICK_DIV), 1);

        // Timeout back to IDLE: the next tap arms only, and 40 ms later
        // it sets the period.
        applyStimulus(220, 1'b0, 0);
        checkOutput("period_after_timeout_tap", period_ms, 65);
        applyStimulus(40, 1'b1, 40);

        // Reset 30 ms into a measurement.
        waitUntil(last_press + 30 * TICK_DIV);
        rst = 1'b1;
        #1;
        checkOutput("midrun_reset_period_ms", period_ms, DEFAULT_MS);
        checkOutput("midrun_reset_valid", period_valid, 0);
        checkOutput("midrun_reset_indicator", indicator, 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst  = 1'b0;
        cyc0 = cyc;
        last_press = 2 * TICK_DIV;
        applyStimulus(0, 1'b0, 0);
        applyStimulus(70, 1'b1, 70);

        repeat (20) @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        if (fail_cnt != 0) $display("[TB] %0d comparisons did not match", fail_cnt);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
